button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/system_pkg.sv | 14 +
 rtl/button_debounce_bit.sv | 64 ++++++
 rtl/button_debounce.sv | 50 +++++
 tb/tb_button_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/system_pkg.sv
// System-wide constants shared by the peripheral blocks.
`default_nettype none

package system_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int DEBOUNCE_MS = 1;

    // Cycles of stable input needed before a button level change is accepted.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

endpackage

`default_nettype wire

// File: rtl/button_debounce_bit.sv
// One button channel: two-flop synchronizer, stability counter, debounced level and edge pulses.
`default_nettype none

module button_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic press_next
);

    localparam int               CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          in_norm;
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          differ;
    logic          accept;
    logic          release_next;

    assign in_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    always_comb begin
        differ       = (sync2 != btn_level);
        accept       = differ && (count == C_LAST);
        press_next   = accept && sync2;
        release_next = accept && !sync2;
    end

    // Any sample equal to the current level discards partial qualification.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            count       <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= in_norm;
            sync2       <= sync1;
            btn_press   <= press_next;
            btn_release <= release_next;
            if (!differ) begin
                count <= '0;
            end else if (accept) begin
                count     <= '0;
                btn_level <= sync2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// Multi-channel pushbutton debouncer with per-channel press/release pulses.
`default_nettype none

module button_debounce
    import system_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             press_any
);

    logic [WIDTH-1:0] press_next;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            button_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_bit (
                .clk         (clk),
                .reset_n     (reset_n),
                .btn_raw     (btn_raw[i]),
                .btn_level   (btn_level[i]),
                .btn_press   (btn_press[i]),
                .btn_release (btn_release[i]),
                .press_next  (press_next[i])
            );
        end
    endgenerate

    // Registered from the same next-state terms so it aligns with btn_press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_any <= 1'b0;
        end else begin
            press_any <= |press_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// Randomized and directed self-checking bench for button_debounce against a run-length model.
`default_nettype none

module tb_button_debounce;

    localparam int WIDTH = 8;
    localparam int DC    = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;
    logic             press_any;

    button_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .press_any   (press_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pressed-value history seen through a 2-edge sync delay, plus a run length per channel.
    logic [WIDTH-1:0] m_d1, m_d2, m_lvl, m_press, m_rel;
    logic             m_any;
    int               run_len [WIDTH];

    int               edge_cnt = 0;
    int               last_press_edge = -1;
    int               last_rel_edge = -1;
    logic [WIDTH-1:0] last_press = '0;
    logic [WIDTH-1:0] last_rel = '0;
    int               press_cnt [WIDTH];
    int               rel_cnt [WIDTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_cnt, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < WIDTH; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
        end
    endtask

    task automatic step(input logic [WIDTH-1:0] raw, input logic rn);
        logic [WIDTH-1:0] view;
        btn_raw = raw;
        reset_n = rn;
        @(posedge clk);
        edge_cnt++;
        if (!rn) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
            for (int c = 0; c < WIDTH; c++) run_len[c] = 0;
        end else begin
            view    = m_d2;
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < WIDTH; c++) begin
                run_len[c] = (view[c] != m_lvl[c]) ? run_len[c] + 1 : 0;
                if (run_len[c] == DC) begin
                    run_len[c] = 0;
                    m_lvl[c]   = view[c];
                    m_press[c] = view[c];
                    m_rel[c]   = ~view[c];
                end
            end
            m_d2 = m_d1;
            m_d1 = ~raw;
        end
        m_any = |m_press;
        #1;
        check("level",   32'(btn_level),   32'(m_lvl));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
        check("any",     32'(press_any),   32'(m_any));
        if (btn_press != '0) begin last_press_edge = edge_cnt; last_press = btn_press; end
        if (btn_release != '0) begin last_rel_edge = edge_cnt; last_rel = btn_release; end
        for (int c = 0; c < WIDTH; c++) begin
            if (btn_press[c])   press_cnt[c]++;
            if (btn_release[c]) rel_cnt[c]++;
        end
    endtask

    task automatic hold(input logic [WIDTH-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b1);
    endtask

    initial begin
        int               s;
        int               tot;
        logic [WIDTH-1:0] r;
        btn_raw = '1;
        reset_n = 1'b0;
        clear_counts();

        // Reset with all released, then idle.
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
        check("rst_level", 32'(btn_level), 32'h0);
        hold(8'hFF, 20);
        tot = 0;
        for (int c = 0; c < WIDTH; c++) tot += press_cnt[c] + rel_cnt[c];
        check("idle_pulses", 32'(tot), 32'h0);

        // All channels pressed at once, then released at once.
        s = edge_cnt;
        hold(8'h00, 10);
        check("all_press_vec", 32'(last_press), 32'hFF);
        check("all_press_lat", 32'(last_press_edge - s), 32'd6);
        check("all_press_once", 32'(press_cnt[5]), 32'd1);
        s = edge_cnt;
        hold(8'hFF, 10);
        check("all_rel_vec", 32'(last_rel), 32'hFF);
        check("all_rel_lat", 32'(last_rel_edge - s), 32'd6);
        check("all_rel_level", 32'(btn_level), 32'h00);

        // Clean step on channel 0.
        clear_counts();
        s = edge_cnt;
        hold(8'hFE, 10);
        check("ch0_press_lat", 32'(last_press_edge - s), 32'd6);
        check("ch0_press_vec", 32'(last_press), 32'h01);
        check("ch0_press_once", 32'(press_cnt[0]), 32'd1);
        check("ch0_level", 32'(btn_level), 32'h01);

        // Bounce on channel 3, toggling every 2 edges, then settle pressed.
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            r    = 8'hFE;
            r[3] = ((i / 2) % 2) != 0;
            step(r, 1'b1);
        end
        check("ch3_bounce_pulses", 32'(press_cnt[3] + rel_cnt[3]), 32'h0);
        s = edge_cnt;
        hold(8'hF6, 10);
        check("ch3_press_lat", 32'(last_press_edge - s), 32'd6);
        check("ch3_level", 32'(btn_level), 32'h09);

        // Release all, then reset mid-qualification of channel 1.
        hold(8'hFF, 10);
        clear_counts();
        hold(8'hFD, 4);
        step(8'hFD, 1'b0);
        step(8'hFD, 1'b0);
        check("rst_mid_pulses", 32'(press_cnt[1]), 32'h0);
        s = edge_cnt;
        hold(8'hFD, 10);
        check("rst_mid_press_lat", 32'(last_press_edge - s), 32'd6);
        check("rst_mid_press_once", 32'(press_cnt[1]), 32'd1);
        hold(8'hFF, 10);

        // Single-edge glitch on channel 7.
        clear_counts();
        step(8'h7F, 1'b1);
        hold(8'hFF, 10);
        check("ch7_glitch_pulses", 32'(press_cnt[7] + rel_cnt[7]), 32'h0);
        check("ch7_glitch_level", 32'(btn_level[7]), 32'h0);

        // Randomized bouncing with occasional reset.
        r = '1;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < WIDTH; c++)
                if ($urandom_range(0, 7) == 0) r[c] = ~r[c];
            step(r, ($urandom_range(0, 99) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
